uv_rst_seq: RTL and testbench
=============================

Name: uv_rst_seq

Overview:
- Consumes the LDO power-on-reset output plus external, watchdog and software reset requests.
- Synchronizes all requests into the clk domain.
- Releases three reset domains in a fixed, counted order: peripheral, then system bus, then core.
- Records the cause of the last reset for boot software and holds all domains in reset while any request is active.

Parameters:
- SYNC_STAGES, 2, synchronizer flop depth for asynchronous request inputs (min 2).
- STABLE_CYCLES, 64, cycles all requests must be inactive before the release sequence starts.
- STEP_CYCLES, 16, cycles between consecutive domain releases.
- CNT_W, 8, counter width; must hold max(STABLE_CYCLES, STEP_CYCLES, DEB_CYCLES).
- DEB_CYCLES, 32, debounce window for ext_rst_n (used only with the optional feature).

Ports:
- clk  input  1  free-running reference clock.
- rst_n  input  1  asynchronous active-low reset of this block.
- por_rst_n  input  1  power-on reset from LDO; low = supply not good; asynchronous.
- ext_rst_n  input  1  external pin reset, active-low; asynchronous.
- wdt_rst_req  input  1  watchdog reset request, active-high; synchronous to clk, level.
- sw_rst_req  input  1  software reset request, active-high; synchronous single-cycle pulse.
- periph_rst_n  output  1  peripheral domain reset, active-low.
- sys_rst_n  output  1  system bus domain reset, active-low.
- core_rst_n  output  1  core domain reset, active-low.
- rst_done  output  1  high when all domains are released.
- rst_cause  output  4  one-hot last cause: [0] POR, [1] EXT, [2] WDT, [3] SW.

Behaviour:
- Clock and reset: one clock. rst_n is asynchronous, active-low. While rst_n is low:
  - all reset outputs = 0, rst_done = 0;
  - rst_cause = 4'b0001;
  - state = HOLD, counter = 0.
- Synchronization:
  - por_rst_n and ext_rst_n each pass through a SYNC_STAGES flop chain.
  - Chain flops are asynchronously set to 0 when rst_n is low.
  - Deassertion therefore takes SYNC_STAGES cycles to be seen internally.
- Internal request: req = ~por_s | ~ext_s | wdt_rst_req | sw_pulse_latched.
  - sw_rst_req is latched for one cycle into the request term so a single pulse forces HOLD.
- FSM states: HOLD, STABLE, REL_PERIPH, REL_SYS, REL_CORE, RUN.
  - HOLD: all outputs 0. Move to STABLE when req = 0; counter cleared.
  - STABLE: counter increments each cycle. If req = 1, return to HOLD. When counter == STABLE_CYCLES-1, go to REL_PERIPH.
  - REL_PERIPH: periph_rst_n = 1. Count STEP_CYCLES, then go to REL_SYS.
  - REL_SYS: sys_rst_n = 1. Count STEP_CYCLES, then go to REL_CORE.
  - REL_CORE: core_rst_n = 1. Next cycle go to RUN.
  - RUN: rst_done = 1.
- Request during sequence or RUN: any req = 1 in any state goes to HOLD on the next clock. All outputs drop to 0 on that same edge (registered; 1-cycle latency from internal request).
- All outputs are registered and glitch-free; no output is driven combinationally from an input.
- Cause capture: on the transition into HOLD from any other state, rst_cause is loaded one-hot with priority POR > EXT > WDT > SW. If req drops and re-asserts while in HOLD, the cause is not updated.
- Timing from last req deassert (internal) to outputs:
  - periph_rst_n rises after STABLE_CYCLES+1 cycles;
  - sys_rst_n after a further STEP_CYCLES;
  - core_rst_n after a further STEP_CYCLES;
  - rst_done one cycle after core_rst_n.
- Counter saturates and does not wrap; it is cleared on every state change.
- Simultaneous events:
  - sw_rst_req and wdt_rst_req in the same cycle: cause = WDT.
  - POR low together with anything: cause = POR.

Optional Feature:
- Macro: UV_RST_DEBOUNCE_EN.
- Defined:
  - Synchronized ext_rst_n must hold a new level for DEB_CYCLES consecutive cycles before the internal ext level changes.
  - Glitches shorter than DEB_CYCLES are ignored.
  - The debounce counter resets to 0 and the debounced level resets to 0 (asserted) under rst_n.
- Undefined: the synchronized ext_rst_n is used directly and DEB_CYCLES is unused.

Test Plan:
- Power-up: rst_n released at t0, por_rst_n rises at cycle 10, others inactive, defaults:
  - periph_rst_n rises at cycle 10+2+64+1 = 77;
  - sys_rst_n at 93, core_rst_n at 109, rst_done at 110;
  - rst_cause = 0001.
- Watchdog in RUN: 1-cycle wdt_rst_req -> all outputs 0 on next edge, rst_cause = 0100, full sequence repeats.
- Software reset pulse in RUN -> outputs low next edge, rst_cause = 1000; same-cycle sw + wdt -> rst_cause = 0100.
- Request during STABLE: ext_rst_n pulses low for 5 cycles at counter = 40 -> returns to HOLD, counter restarts. Without the macro, rst_cause = 0010. With UV_RST_DEBOUNCE_EN, the pulse is ignored and the sequence completes on schedule.
- Brown-out mid-sequence: por_rst_n falls while in REL_SYS -> periph/sys outputs drop to 0 after sync latency + 1 cycle, rst_cause = 0001.
- rst_n asserted asynchronously in RUN mid-cycle -> all outputs 0 immediately, without a clock edge.

Source files
------------

// File: rtl/uv_rst_seq.sv
// uv_rst_seq: reset sequencer. Synchronizes POR / external / watchdog / software
// reset requests and releases the peripheral, system-bus and core domains in a
// fixed, counted order. Records the cause of the last reset.
// Optional build macro UV_RST_DEBOUNCE_EN: debounce the synchronized ext_rst_n
// over DEB_CYCLES consecutive cycles before the internal level follows it.
module uv_rst_seq #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 64,
  parameter int unsigned STEP_CYCLES   = 16,
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned DEB_CYCLES    = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       por_rst_n,
  input  logic       ext_rst_n,
  input  logic       wdt_rst_req,
  input  logic       sw_rst_req,
  output logic       periph_rst_n,
  output logic       sys_rst_n,
  output logic       core_rst_n,
  output logic       rst_done,
  output logic [3:0] rst_cause
);

  typedef enum logic [2:0] {
    HOLD,
    STABLE,
    REL_PERIPH,
    REL_SYS,
    REL_CORE,
    RUN
  } state_e;

  localparam int unsigned MAX_SS  = (STABLE_CYCLES > STEP_CYCLES) ? STABLE_CYCLES : STEP_CYCLES;
  localparam int unsigned CNT_MAX = (MAX_SS > DEB_CYCLES) ? MAX_SS : DEB_CYCLES;

  localparam logic [CNT_W-1:0] CNT_SAT     = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STEP_LAST   = CNT_W'(STEP_CYCLES - 1);

  logic [SYNC_STAGES-1:0] por_sync_q, por_sync_d;
  logic [SYNC_STAGES-1:0] ext_sync_q, ext_sync_d;
  logic                   por_s;
  logic                   ext_s;
  logic                   ext_i;
  logic                   sw_q, sw_d;
  logic                   req;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [3:0]             cause_q, cause_d;
  logic                   periph_q, periph_d;
  logic                   sys_q, sys_d;
  logic                   core_q, core_d;
  logic                   done_q, done_d;

  // Synchronizer shift and software-pulse capture
  always_comb begin
    por_sync_d = {por_sync_q[SYNC_STAGES-2:0], por_rst_n};
    ext_sync_d = {ext_sync_q[SYNC_STAGES-2:0], ext_rst_n};
    sw_d       = sw_rst_req;
  end

  // Synchronizer chains clear to 0 so every domain starts in reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      por_sync_q <= '0;
      ext_sync_q <= '0;
      sw_q       <= 1'b0;
    end else begin
      por_sync_q <= por_sync_d;
      ext_sync_q <= ext_sync_d;
      sw_q       <= sw_d;
    end
  end

  assign por_s = por_sync_q[SYNC_STAGES-1];
  assign ext_s = ext_sync_q[SYNC_STAGES-1];

`ifdef UV_RST_DEBOUNCE_EN
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             ext_lvl_q, ext_lvl_d;
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

  // Internal ext level flips only after DEB_CYCLES consecutive differing samples
  always_comb begin
    deb_cnt_d = deb_cnt_q;
    ext_lvl_d = ext_lvl_q;
    if (ext_s == ext_lvl_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DEB_LAST) begin
      ext_lvl_d = ext_s;
      deb_cnt_d = '0;
    end else begin
      deb_cnt_d = deb_cnt_q + 1'b1;
    end
  end

  // Debounce state register; level starts asserted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt_q <= '0;
      ext_lvl_q <= 1'b0;
    end else begin
      deb_cnt_q <= deb_cnt_d;
      ext_lvl_q <= ext_lvl_d;
    end
  end

  assign ext_i = ext_lvl_q;
`else
  assign ext_i = ext_s;
`endif

  assign req = ~por_s | ~ext_i | wdt_rst_req | sw_q;

  // Next state, counter, cause capture and registered output values
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;

    unique case (state_q)
      HOLD:       state_d = STABLE;
      STABLE:     if (cnt_q == STABLE_LAST) state_d = REL_PERIPH;
      REL_PERIPH: if (cnt_q == STEP_LAST) state_d = REL_SYS;
      REL_SYS:    if (cnt_q == STEP_LAST) state_d = REL_CORE;
      REL_CORE:   state_d = RUN;
      RUN:        state_d = RUN;
      default:    state_d = HOLD;
    endcase

    // Any request wins over sequencing; the cause is captured only on entry
    if (req) begin
      state_d = HOLD;
      if (state_q != HOLD) begin
        if (!por_s)           cause_d = 4'b0001;
        else if (!ext_i)      cause_d = 4'b0010;
        else if (wdt_rst_req) cause_d = 4'b0100;
        else                  cause_d = 4'b1000;
      end
    end

    if (state_d != state_q || state_q == HOLD) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_SAT) begin
      cnt_d = cnt_q + 1'b1;
    end

    periph_d = state_d inside {REL_PERIPH, REL_SYS, REL_CORE, RUN};
    sys_d    = state_d inside {REL_SYS, REL_CORE, RUN};
    core_d   = state_d inside {REL_CORE, RUN};
    done_d   = (state_d == RUN);
  end

  // Sequencer state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= HOLD;
      cnt_q    <= '0;
      cause_q  <= 4'b0001;
      periph_q <= 1'b0;
      sys_q    <= 1'b0;
      core_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cause_q  <= cause_d;
      periph_q <= periph_d;
      sys_q    <= sys_d;
      core_q   <= core_d;
      done_q   <= done_d;
    end
  end

  assign periph_rst_n = periph_q;
  assign sys_rst_n    = sys_q;
  assign core_rst_n   = core_q;
  assign rst_done     = done_q;
  assign rst_cause    = cause_q;

endmodule

// File: tb/tb_uv_rst_seq.sv
// Bench for uv_rst_seq: run-length reference model plus directed literal checks.
module tb_uv_rst_seq;

  localparam int SYNC   = 2;
  localparam int STABLE = 64;
  localparam int STEP   = 16;
  localparam int DEB    = 32;
`ifdef UV_RST_DEBOUNCE_EN
  localparam int O = 22;
`else
  localparam int O = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       por_rst_n = 1'b0;
  logic       ext_rst_n = 1'b1;
  logic       wdt_rst_req = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic       periph_rst_n, sys_rst_n, core_rst_n, rst_done;
  logic [3:0] rst_cause;

  int n_pass = 0;
  int n_total = 0;
  int ecnt = 0;

  uv_rst_seq #(
    .SYNC_STAGES  (SYNC),
    .STABLE_CYCLES(STABLE),
    .STEP_CYCLES  (STEP),
    .CNT_W        (8),
    .DEB_CYCLES   (DEB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .por_rst_n   (por_rst_n),
    .ext_rst_n   (ext_rst_n),
    .wdt_rst_req (wdt_rst_req),
    .sw_rst_req  (sw_rst_req),
    .periph_rst_n(periph_rst_n),
    .sys_rst_n   (sys_rst_n),
    .core_rst_n  (core_rst_n),
    .rst_done    (rst_done),
    .rst_cause   (rst_cause)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rst_n) ecnt <= ecnt + 1;

  // Reference model: m_q = number of consecutive edges that saw no request
  int              m_q = 0;
  logic [3:0]      m_cause = 4'b0001;
  logic [SYNC-1:0] m_por = '0;
  logic [SYNC-1:0] m_ext = '0;
  logic            m_swq = 1'b0;
  logic            m_lvl = 1'b0;
  int              m_run = 0;
  logic            m_ext_now;
  logic            m_req;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q = 0; m_cause = 4'b0001; m_por = '0; m_ext = '0;
      m_swq = 1'b0; m_lvl = 1'b0; m_run = 0;
    end else begin
`ifdef UV_RST_DEBOUNCE_EN
      m_ext_now = m_lvl;
`else
      m_ext_now = m_ext[SYNC-1];
`endif
      m_req = !m_por[SYNC-1] || !m_ext_now || wdt_rst_req || m_swq;
      if (m_req) begin
        if (m_q != 0) begin
          if (!m_por[SYNC-1])   m_cause = 4'b0001;
          else if (!m_ext_now)  m_cause = 4'b0010;
          else if (wdt_rst_req) m_cause = 4'b0100;
          else                  m_cause = 4'b1000;
        end
        m_q = 0;
      end else if (m_q < 100000) begin
        m_q = m_q + 1;
      end
`ifdef UV_RST_DEBOUNCE_EN
      if (m_ext[SYNC-1] != m_lvl) begin
        m_run = m_run + 1;
        if (m_run == DEB) begin
          m_lvl = m_ext[SYNC-1];
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
`endif
      m_por = {m_por[SYNC-2:0], por_rst_n};
      m_ext = {m_ext[SYNC-2:0], ext_rst_n};
      m_swq = sw_rst_req;
    end
  end

  function automatic logic [7:0] model_vec();
    return {m_q >= STABLE + 1,
            m_q >= STABLE + 1 + STEP,
            m_q >= STABLE + 1 + 2 * STEP,
            m_q >= STABLE + 2 + 2 * STEP,
            m_cause};
  endfunction

  function automatic logic [7:0] dut_vec();
    return {periph_rst_n, sys_rst_n, core_rst_n, rst_done, rst_cause};
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (edge %0d, t=%0t)", name, got, exp, ecnt, $time);
  endtask

  // Continuous comparison against the model, away from the active edge
  always @(negedge clk) check("model", dut_vec(), model_vec());

  task automatic wait_edge(input int k);
    while (ecnt < k) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  // Directed stimulus with hand-computed vector {periph,sys,core,done,cause}
  initial begin
    repeat (3) @(negedge clk);
    check("reset_state", dut_vec(), 8'b0000_0001);
    rst_n = 1'b1;

    // Power-up: por released after edge 10
    wait_edge(10);  por_rst_n = 1'b1;
    wait_edge(76 + O);  check("pu_periph_low",  dut_vec(), 8'b0000_0001);
    wait_edge(77 + O);  check("pu_periph_high", dut_vec(), 8'b1000_0001);
    wait_edge(92 + O);  check("pu_sys_low",     dut_vec(), 8'b1000_0001);
    wait_edge(93 + O);  check("pu_sys_high",    dut_vec(), 8'b1100_0001);
    wait_edge(108 + O); check("pu_core_low",    dut_vec(), 8'b1100_0001);
    wait_edge(109 + O); check("pu_core_high",   dut_vec(), 8'b1110_0001);
    wait_edge(110 + O); check("pu_done",        dut_vec(), 8'b1111_0001);

    // Watchdog pulse in RUN
    wait_edge(120 + O); wdt_rst_req = 1'b1;
    wait_edge(121 + O); wdt_rst_req = 1'b0;
    check("wdt_drop", dut_vec(), 8'b0000_0100);
    wait_edge(218 + O); check("wdt_core", dut_vec(), 8'b1110_0100);
    wait_edge(219 + O); check("wdt_done", dut_vec(), 8'b1111_0100);

    // Software pulse in RUN (one cycle of latching before HOLD)
    wait_edge(230 + O); sw_rst_req = 1'b1;
    wait_edge(231 + O); sw_rst_req = 1'b0;
    check("sw_latched", dut_vec(), 8'b1111_0100);
    wait_edge(232 + O); check("sw_drop",  dut_vec(), 8'b0000_1000);
    wait_edge(329 + O); check("sw_core",  dut_vec(), 8'b1110_1000);
    wait_edge(330 + O); check("sw_done",  dut_vec(), 8'b1111_1000);

    // Simultaneous software and watchdog: watchdog wins
    wait_edge(340 + O); sw_rst_req = 1'b1; wdt_rst_req = 1'b1;
    wait_edge(341 + O); sw_rst_req = 1'b0; wdt_rst_req = 1'b0;
    check("swwdt_drop", dut_vec(), 8'b0000_0100);
    wait_edge(342 + O); check("swwdt_hold", dut_vec(), 8'b0000_0100);

    // External glitch at STABLE counter 40
    wait_edge(383 + O); ext_rst_n = 1'b0;
    wait_edge(388 + O); ext_rst_n = 1'b1;
`ifdef UV_RST_DEBOUNCE_EN
    wait_edge(439 + O); check("ext_ignored_core", dut_vec(), 8'b1110_0100);
    wait_edge(440 + O); check("ext_ignored_done", dut_vec(), 8'b1111_0100);
`else
    wait_edge(386 + O); check("ext_hold",  dut_vec(), 8'b0000_0010);
    wait_edge(487 + O); check("ext_core",  dut_vec(), 8'b1110_0010);
    wait_edge(488 + O); check("ext_done",  dut_vec(), 8'b1111_0010);
`endif

    // Brown-out in REL_SYS
    wait_edge(500 + O); wdt_rst_req = 1'b1;
    wait_edge(501 + O); wdt_rst_req = 1'b0;
    wait_edge(585 + O); por_rst_n = 1'b0;
    wait_edge(587 + O); check("bo_pre",  dut_vec(), 8'b1100_0100);
    wait_edge(588 + O); check("bo_drop", dut_vec(), 8'b0000_0001);
    wait_edge(595 + O); por_rst_n = 1'b1;
    wait_edge(694 + O); check("bo_core", dut_vec(), 8'b1110_0001);
    wait_edge(695 + O); check("bo_done", dut_vec(), 8'b1111_0001);

    // Asynchronous rst_n in RUN, between clock edges
    wait_edge(710 + O);
    #2 rst_n = 1'b0;
    #1 check("async_rst", dut_vec(), 8'b0000_0001);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (140) @(negedge clk);
    check("post_rst_run", dut_vec(), 8'b1111_0001);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
